// File: rtl/mdu_if.sv
// Request/result bundle between the execute-stage controller and the multiply/divide unit.
// Master drives the request and read select; slave returns busy, HI/LO and the read port.
interface mdu_if;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadSel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] RD;

    modport master (
        output start, MDUOp, A, B, ReadSel,
        input  busy, HI, LO, RD
    );

    modport slave (
        input  start, MDUOp, A, B, ReadSel,
        output busy, HI, LO, RD
    );
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit: mult/multu/div/divu into private HI/LO, single-cycle mthi/mtlo.
// Latency: MULT_CYCLES or DIV_CYCLES edges to commit; mthi/mtlo visible the cycle after acceptance.
// Backpressure: none queued; requests while busy are dropped, so the controller must stall on busy.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dz_q, dz_d;

    logic signed [63:0] a_sx, b_sx;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b, abs_a, abs_b, quo_mag, rem_mag;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        b_zero;

    // Arithmetic datapath, evaluated on the live operands; only the start edge captures it.
    always_comb begin
        a_sx    = {{32{bus.A[31]}}, bus.A};
        b_sx    = {{32{bus.B[31]}}, bus.B};
        prod_s  = a_sx * b_sx;
        prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
        b_zero  = (bus.B == 32'd0);
        div_b   = b_zero ? 32'd1 : bus.B;
        // Magnitude form sidesteps the 0x80000000 / -1 overflow of native signed division.
        abs_a   = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
        abs_b   = div_b[31] ? (~div_b + 32'd1) : div_b;
        quo_mag = abs_a / abs_b;
        rem_mag = abs_a % abs_b;
        quo_s   = (bus.A[31] ^ div_b[31]) ? (~quo_mag + 32'd1) : quo_mag;
        rem_s   = bus.A[31] ? (~rem_mag + 32'd1) : rem_mag;
        quo_u   = bus.A / div_b;
        rem_u   = bus.A % div_b;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        phi_d = phi_q;
        plo_d = plo_q;
        cnt_d = cnt_q;
        dz_d  = dz_q;
        if (cnt_q != 4'd0) begin
            if (cnt_q == 4'd1) begin
                cnt_d = 4'd0;
                if (!dz_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (bus.start) begin
            case (bus.MDUOp)
                OP_MULT: begin
                    phi_d = prod_s[63:32];
                    plo_d = prod_s[31:0];
                    dz_d  = 1'b0;
                    cnt_d = 4'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    phi_d = prod_u[63:32];
                    plo_d = prod_u[31:0];
                    dz_d  = 1'b0;
                    cnt_d = 4'(MULT_CYCLES);
                end
                OP_DIV: begin
                    phi_d = rem_s;
                    plo_d = quo_s;
                    dz_d  = b_zero;
                    cnt_d = 4'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    phi_d = rem_u;
                    plo_d = quo_u;
                    dz_d  = b_zero;
                    cnt_d = 4'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = bus.A;
                OP_MTLO: lo_d = bus.A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            phi_q <= 32'd0;
            plo_q <= 32'd0;
            cnt_q <= 4'd0;
            dz_q  <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            cnt_q <= cnt_d;
            dz_q  <= dz_d;
        end
    end

    assign bus.busy = (cnt_q != 4'd0);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.RD   = bus.ReadSel ? hi_q : lo_q;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy windows, ignored requests and async reset.
module tb_mdu;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request for exactly one rising edge; returns at the following negedge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.A     = 32'hDEADBEEF;
        bus.B     = 32'h0BADF00D;
    endtask

    // Expects busy for exactly n sampled cycles with RD holding its old value, then idle.
    task automatic expect_busy(input string tag, input int n, input logic [31:0] rd_old);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_rd_old"}, bus.RD, rd_old);
            @(negedge clk);
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.MDUOp   = 3'd0;
        bus.A       = 32'd0;
        bus.B       = 32'd0;
        bus.ReadSel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_rd", bus.RD, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Signed multiply; operands are scrambled by run_op after the start edge.
        bus.ReadSel = 1'b1;
        run_op(3'd1, 32'hFFFFFFFE, 32'h00000003);
        expect_busy("mult", 5, 32'h00000000);
        check("mult_hi", bus.HI, 32'hFFFFFFFF);
        check("mult_lo", bus.LO, 32'hFFFFFFFA);
        check("mult_rd_hi", bus.RD, 32'hFFFFFFFF);

        run_op(3'd2, 32'hFFFFFFFF, 32'h00000002);
        expect_busy("multu", 5, 32'hFFFFFFFF);
        check("multu_hi", bus.HI, 32'h00000001);
        check("multu_lo", bus.LO, 32'hFFFFFFFE);

        bus.ReadSel = 1'b0;
        run_op(3'd3, 32'hFFFFFFF9, 32'h00000002);
        expect_busy("div", 10, 32'hFFFFFFFE);
        check("div_lo", bus.LO, 32'hFFFFFFFD);
        check("div_hi", bus.HI, 32'hFFFFFFFF);

        run_op(3'd4, 32'h00000007, 32'h00000000);
        expect_busy("divz", 10, 32'hFFFFFFFD);
        check("divz_hi", bus.HI, 32'hFFFFFFFF);
        check("divz_lo", bus.LO, 32'hFFFFFFFD);

        // 100 / 7 with mult and mthi requests thrown in while busy.
        run_op(3'd3, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            check("ign_busy", 32'(bus.busy), 32'd1);
            check("ign_hi_old", bus.HI, 32'hFFFFFFFF);
            if (i == 1) begin
                bus.start = 1'b1; bus.MDUOp = 3'd1; bus.A = 32'd5; bus.B = 32'd5;
            end else if (i == 2) begin
                bus.start = 1'b1; bus.MDUOp = 3'd5; bus.A = 32'hCAFEBABE;
            end else if (i == 3) begin
                bus.start = 1'b0; bus.MDUOp = 3'd0;
            end
            @(negedge clk);
        end
        check("ign_idle", 32'(bus.busy), 32'd0);
        check("ign_lo", bus.LO, 32'd14);
        check("ign_hi", bus.HI, 32'd2);

        run_op(3'd6, 32'h12345678, 32'd0);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        check("mtlo_lo", bus.LO, 32'h12345678);
        check("mtlo_rd", bus.RD, 32'h12345678);
        check("mtlo_hi", bus.HI, 32'd2);

        run_op(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("op7_busy", 32'(bus.busy), 32'd0);
        check("op7_hi", bus.HI, 32'd2);
        check("op7_lo", bus.LO, 32'h12345678);

        // Overflow divide, then a mult issued in the first idle cycle.
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        expect_busy("ovf", 10, 32'h12345678);
        check("ovf_lo", bus.LO, 32'h80000000);
        check("ovf_hi", bus.HI, 32'h00000000);
        run_op(3'd1, 32'd3, 32'd4);
        expect_busy("b2b", 5, 32'h80000000);
        check("b2b_lo", bus.LO, 32'd12);
        check("b2b_hi", bus.HI, 32'd0);

        run_op(3'd5, 32'hA5A5A5A5, 32'd0);
        check("mthi_hi", bus.HI, 32'hA5A5A5A5);
        check("mthi_busy", 32'(bus.busy), 32'd0);

        // Async reset with three cycles left on the counter.
        run_op(3'd1, 32'd7, 32'd7);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hi", bus.HI, 32'd0);
        check("arst_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_hi", bus.HI, 32'd0);
        check("post_rst_lo", bus.LO, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the MIPS datapath. Sits beside the ALU in the execute stage and consumes the two GRF read ports (RD1 = rs, RD2 = rt). Runs `mult`, `multu`, `div` and `divu` as multi-cycle operations into private HI/LO registers, and executes `mthi`/`mtlo` in a single cycle. Provides HI or LO on a read port for `mfhi`/`mflo`, which the datapath routes into the GRF write-data mux. Exports `busy` so the controller can stall any MDU instruction that would collide with a running operation.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for `mult`/`multu`; legal range 1..15.
- DIV_CYCLES, 10, cycles `busy` stays high for `div`/`divu`; legal range 1..15.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- start  input  1  one-cycle request; sampled with MDUOp, A and B at the rising edge
- MDUOp  input  3  operation code:
  - 0 none
  - 1 mult
  - 2 multu
  - 3 div
  - 4 divu
  - 5 mthi
  - 6 mtlo
  - 7 reserved, treated as none
- A  input  32  operand rs (RD1)
- B  input  32  operand rt (RD2)
- ReadSel  input  1  0 selects LO, 1 selects HI on RD
- busy  output  1  registered; high while a multi-cycle operation is in flight
- HI  output  32  registered HI
- LO  output  32  registered LO
- RD  output  32  combinational: ReadSel ? HI : LO

## Operation
- **State:** HI, LO, a 4-bit down-counter `cnt`, pending result registers `pHI`/`pLO`, and `busy = (cnt != 0)`.
- **Accepted request:** any edge where start=1, busy=0 and MDUOp is 1..6.
- **mult:**
  - Takes the signed 64-bit product of A and B.
  - pHI gets the upper 32 bits, pLO the lower 32 bits.
  - cnt is loaded with MULT_CYCLES.
- **multu:** same as mult, but with an unsigned product.
- **div:**
  - Signed division; the quotient truncates toward zero and the remainder takes the sign of the dividend.
  - pLO gets the quotient, pHI the remainder.
  - cnt is loaded with DIV_CYCLES.
  - 0x80000000 / 0xFFFFFFFF yields pLO = 0x80000000, pHI = 0.
- **divu:** same as div, but unsigned.
- **Divide by zero (B=0):**
  - The unit still goes busy for DIV_CYCLES.
  - HI and LO are left unchanged at completion.
  - The divide-by-zero condition is latched at the start edge.
- **Counting and commit:**
  - While cnt > 1, cnt decrements on each edge.
  - At the edge where cnt == 1: cnt becomes 0, and HI ← pHI, LO ← pLO, unless the divide-by-zero case is latched.
- **mthi / mtlo:** HI ← A (mthi) or LO ← A (mtlo) at the accepting edge; busy is not asserted.
- **Ignored requests:**
  - start while busy is ignored. The operation in flight is unaffected and no queueing happens; the controller must stall.
  - MDUOp 0 or 7 with start=1 is a no-op.
- **RD:** reflects the current registered HI/LO. It never shows pending values.

## Timing
- **Reset values:** HI=0, LO=0, busy=0, cnt=0, pHI=0, pLO=0. RD=0.
- **Reset mid-operation:** asserting reset aborts the operation, clears everything to the reset values, and commits no result.
- **Multi-cycle latency:** start edge E0 → busy=1 during cycles E0+1 .. E0+N → HI/LO updated and busy=0 from edge E0+N onward (N = MULT_CYCLES or DIV_CYCLES).
- **Back-to-back:** a new start is accepted at edge E0+N itself, i.e. the first cycle in which busy reads 0.
- **mthi / mtlo latency:** the new value is visible on HI/LO/RD in the cycle after the accepting edge.
- **Read during an operation:** RD returns the old HI/LO until the commit edge.
- **Operand hold:** A and B are sampled only at the start edge; later changes during busy have no effect.

## Test plan
- **Reset:** drive reset=0 mid-run with cnt=3 → busy=0 and HI=LO=0 immediately, without waiting for a clock edge. After release, an idle cycle keeps HI=LO=0.
- **Signed multiply:** mult with A=0xFFFFFFFE (-2), B=0x00000003 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. RD with ReadSel=1 shows the old HI until the commit edge.
- **Unsigned multiply:** multu with A=0xFFFFFFFF, B=0x00000002 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- **Signed divide:**
  - div A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - divu A=7, B=0 → busy for 10 cycles, and HI/LO keep their previous values.
- **Start while busy:**
  - During a div, issue mult and mthi, both with start=1 → both ignored, and the div result commits at cycle 10.
  - Then mtlo A=0x12345678 on the first non-busy cycle → LO=0x12345678 one cycle later, with busy never asserted.
- **Overflow divide and back-to-back:** div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. A mult started on the commit cycle is accepted and completes 5 cycles later.
